// File: rtl/reaction_bcd_converter_if.sv
// Request/result bundle between the reaction timer core and the BCD converter.
// master: timer core side (drives start/bin_in, receives results).
// slave:  converter side (receives start/bin_in, drives busy/done/bcd/overflow/blank).
interface reaction_bcd_converter_if #(
   parameter int IN_W   = 14,
   parameter int DIGITS = 4
);
   logic                  start;
   logic [IN_W-1:0]       bin_in;
   logic                  busy;
   logic                  done;
   logic [4*DIGITS-1:0]   bcd;
   logic                  overflow;
   logic [DIGITS-1:0]     blank;

   modport master (
      output start, bin_in,
      input  busy, done, bcd, overflow, blank
   );

   modport slave (
      input  start, bin_in,
      output busy, done, bcd, overflow, blank
   );
endinterface

// File: rtl/reaction_bcd_converter.sv
// Purpose: iterative double-dabble binary-to-BCD converter, saturating to all nines.
// Latency: done pulses IN_W+1 cycles after an accepted start; one conversion per IN_W+2 cycles.
// Backpressure: none; start is only sampled in IDLE, requests while busy are dropped.
// Ports: CLK100MHZ (rising edge), reset (sync, active-high), bus (slave modport):
//   start/bin_in request, busy, done pulse, bcd (digit 0 in [3:0]), overflow, blank mask.
// Build option: define LZ_BLANK_EN to generate the leading-zero blank mask;
//   otherwise blank is tied to zero.
module reaction_bcd_converter #(
   parameter int IN_W   = 14,
   parameter int DIGITS = 4
) (
   input  logic                      CLK100MHZ,
   input  logic                      reset,
   reaction_bcd_converter_if.slave   bus
);

   function automatic int pow10(input int n);
      int r;
      r = 1;
      for (int i = 0; i < n; i++) r = r * 10;
      return r;
   endfunction

   localparam int              BCD_W   = 4 * DIGITS;
   localparam int              CNT_W   = $clog2(IN_W + 1);
   localparam logic [IN_W-1:0] MAX_BIN = IN_W'(pow10(DIGITS) - 1);
   localparam logic [CNT_W-1:0] LAST   = CNT_W'(IN_W - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t              state_q, state_d;
   logic [IN_W-1:0]     shift_q, shift_d;
   logic [BCD_W-1:0]    scratch_q, scratch_d;
   logic [BCD_W-1:0]    adj;
   logic [CNT_W-1:0]    cnt_q;
   logic                ovf_q;
   logic [BCD_W-1:0]    bcd_q;
   logic                overflow_q;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge CLK100MHZ) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start)      state_d = SHIFT;
         SHIFT:   if (cnt_q == LAST)  state_d = DONE;
         DONE:                        state_d = IDLE;
         default:                     state_d = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      bus.busy = (state_q == SHIFT);
      bus.done = (state_q == DONE);
   end

   // One double-dabble step: correct digits >= 5 so the following doubling
   // carries into the next digit, then shift the binary MSB into digit 0.
   always_comb begin
      adj = scratch_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (scratch_q[4*i +: 4] >= 4'd5)
            adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
      scratch_d = {adj[BCD_W-2:0], shift_q[IN_W-1]};
      shift_d   = {shift_q[IN_W-2:0], 1'b0};
   end

   // Datapath. Result registers are loaded on the final shift edge so the new
   // value is already visible during the DONE cycle alongside the done pulse.
   always_ff @(posedge CLK100MHZ) begin
      if (reset) begin
         shift_q    <= '0;
         scratch_q  <= '0;
         cnt_q      <= '0;
         ovf_q      <= 1'b0;
         bcd_q      <= '0;
         overflow_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.start) begin
                  if (bus.bin_in > MAX_BIN) begin
                     shift_q <= MAX_BIN;
                     ovf_q   <= 1'b1;
                  end else begin
                     shift_q <= bus.bin_in;
                     ovf_q   <= 1'b0;
                  end
                  scratch_q <= '0;
                  cnt_q     <= '0;
               end
            end
            SHIFT: begin
               shift_q   <= shift_d;
               scratch_q <= scratch_d;
               cnt_q     <= cnt_q + CNT_W'(1);
               if (cnt_q == LAST) begin
                  bcd_q      <= scratch_d;
                  overflow_q <= ovf_q;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.bcd      = bcd_q;
   assign bus.overflow = overflow_q;

`ifdef LZ_BLANK_EN
   logic [DIGITS-1:0] blank_q, blank_d;
   logic              zero_above;

   // Digit i is blanked when it and every digit above it are zero; digit 0
   // always shows. A saturated result displays every digit.
   always_comb begin
      blank_d    = '0;
      zero_above = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         zero_above = zero_above & (scratch_d[4*i +: 4] == 4'd0);
         blank_d[i] = zero_above;
      end
      if (ovf_q) blank_d = '0;
   end

   always_ff @(posedge CLK100MHZ) begin
      if (reset)
         blank_q <= '0;
      else if (state_q == SHIFT && cnt_q == LAST)
         blank_q <= blank_d;
   end

   assign bus.blank = blank_q;
`else
   assign bus.blank = '0;
`endif

endmodule

// File: doc/reaction_bcd_converter.md
# reaction_bcd_converter

Sequential binary-to-BCD converter between the reaction timer core and the seven-segment scan driver. It accepts a binary millisecond count on a start strobe and runs an iterative shift-and-add-3 (double dabble) conversion, one bit per cycle. It returns packed BCD digits with a one-cycle done pulse. Out-of-range inputs saturate to all nines, which is the "9999" false-start/timeout display. An optional leading-zero blank mask is produced for the display driver.

## Interface
- IN_W, default 14: binary input width; must satisfy 2^IN_W > 10^DIGITS − 1.
- DIGITS, default 4: number of BCD digits produced.
- CLK100MHZ  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  conversion request, sampled only in IDLE.
- bin_in  input  IN_W  binary value, captured on the accepted start cycle.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse; bcd/overflow/blank valid from this cycle.
- bcd  output  4*DIGITS  packed BCD result; digit 0 in [3:0]; held until next done.
- overflow  output  1  set with done when bin_in > 10^DIGITS − 1; held with bcd.
- blank  output  DIGITS  leading-zero mask, bit i = digit i blanked; held with bcd.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: on start=1, capture bin_in into the shift register.
  - If bin_in > 10^DIGITS − 1, capture 10^DIGITS − 1 instead and set the internal ovf flag.
  - Clear the BCD scratch register and bit counter, then go to SHIFT.
- SHIFT: each cycle, add 3 to every scratch digit ≥ 5, then shift {scratch, shifter} left by 1.
  - After exactly IN_W shifts, go to DONE.
- DONE: load the bcd, overflow and blank output registers; done=1 for this cycle only; return to IDLE.
- start while in SHIFT or DONE is ignored; no queuing.
- bin_in is don't-care except on the accepted start cycle.
- Outputs bcd, overflow and blank change only in the DONE cycle or on reset.
- Scratch digits never exceed 9 after the shift; widths are exactly 4 bits per digit.
- Reset in any state: state → IDLE; the conversion in progress is discarded and no done is issued.

## Timing
- Accepted start at cycle 0 (rising edge where state=IDLE and start=1).
- busy=1 in cycles 1..IN_W (the SHIFT cycles); busy=0 in IDLE and DONE.
- done=1 and new bcd visible in cycle IN_W+1 (cycle 15 at default).
- Earliest next accepted start: cycle IN_W+2, i.e. a throughput of one conversion per IN_W+2 cycles.
- Reset values: busy=0, done=0, bcd=0, overflow=0, blank=0, state=IDLE.
- A start held high continuously retriggers every IN_W+2 cycles.

## Configuration
- LZ_BLANK_EN defined: at done, blank[i]=1 for each digit i≥1 for which that digit and all digits above it are zero.
  - Digit 0 is never blanked.
  - blank is forced to 0 when overflow=1.
- LZ_BLANK_EN undefined: the blank port exists but is tied to all zeros; no blanking logic is synthesized.

## Test plan
- Basic conversion: reset, then start with bin_in=1234 → busy high for cycles 1–14, done at cycle 15, bcd=16'h1234, overflow=0, blank=4'b0000.
- Zero and blanking: bin_in=0 → bcd=16'h0000; blank=4'b1110 with LZ_BLANK_EN, 4'b0000 without. Also bin_in=7 → blank=4'b1110 with LZ_BLANK_EN.
- Saturation: bin_in=12000 → bcd=16'h9999, overflow=1, blank=0. A following conversion of 9999 → bcd=16'h9999, overflow=0.
- Start during busy: start=1 in cycle 5 with bin_in=42 → ignored; the result of the original 1234 request is unchanged, and exactly one done pulse occurs.
- Reset mid-operation: reset in cycle 7 → busy=0, bcd=0 next cycle, no done. A fresh start with bin_in=305 → bcd=16'h0305 at cycle 15 after the start; blank=4'b1000 with LZ_BLANK_EN.
- Back-to-back: start held high with values 1, 9998 → dones at cycles 15 and 31, with bcd 16'h0001 then 16'h9998; the result is held between the pulses.
